// File: rtl/cache_fill_arbiter.sv
// N-channel cache-fill / write-through arbiter in front of one pipelined, fixed-latency memory.
// A fill streams a whole block into the granted channel; a write goes through as a single word.

module cache_fill_lane (
  input  logic sel,
  input  logic fill_hit,
  input  logic last_hit,
  output logic fill_we,
  output logic fill_tag_we
);
  assign fill_we     = sel & fill_hit;
  assign fill_tag_we = sel & last_hit;
endmodule

module cache_fill_arbiter #(
  parameter int CHANNELS        = 2,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4,
  parameter int RR_MODE         = 0,
  localparam int OFF_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          req_valid,
  input  logic [CHANNELS-1:0]          req_write,
  input  logic [CHANNELS*ADDR_W-1:0]   req_addr,
  input  logic [CHANNELS*DATA_W-1:0]   req_wdata,
  output logic [CHANNELS-1:0]          grant,
  output logic [CHANNELS-1:0]          done,
  output logic [CHANNELS-1:0]          fill_we,
  output logic [CHANNELS-1:0]          fill_tag_we,
  output logic [OFF_W-1:0]             fill_word,
  output logic [DATA_W-1:0]            fill_data,
  output logic                         busy,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_valid
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW1  = CH_W + 1;
  localparam int OW1  = OFF_W + 1;
  localparam int TAG_W = ADDR_W - OFF_W - 1;
  localparam logic [CH_W:0]    CH_CNT   = CW1'(CHANNELS);
  localparam logic [OFF_W:0]   WPB_CNT  = OW1'(WORDS_PER_BLOCK);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                               state;
  logic [CH_W-1:0]                      chan;
  logic [CH_W-1:0]                      rr_ptr;
  logic [TAG_W-1:0]                     blk_tag;
  logic [OFF_W:0]                       iss_cnt;
  logic [OFF_W-1:0]                     rcv_cnt;

  logic [CHANNELS-1:0][ADDR_W-1:0]      req_addr_a;
  logic [CHANNELS-1:0][DATA_W-1:0]      req_wdata_a;
  assign req_addr_a  = req_addr;
  assign req_wdata_a = req_wdata;

  // Arbitration: rotate the request vector so the search always starts at bit 0,
  // pick the lowest set bit, then rotate the pick back into channel space.
  logic [CH_W-1:0]       ptr_eff, rot_pick, arb_idx, rr_next;
  logic [2*CHANNELS-1:0] req_dbl;
  logic [CHANNELS-1:0]   req_rot;
  logic [CH_W:0]         arb_sum, nxt_sum;
  logic                  arb_any;

  assign ptr_eff = (RR_MODE != 0) ? rr_ptr : '0;
  assign req_dbl = {req_valid, req_valid} >> ptr_eff;
  assign req_rot = req_dbl[CHANNELS-1:0];
  assign arb_any = |req_valid;

  always_comb begin
    rot_pick = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (req_rot[i]) rot_pick = CH_W'(i);
  end

  assign arb_sum = {1'b0, rot_pick} + {1'b0, ptr_eff};
  assign arb_idx = (arb_sum >= CH_CNT) ? CH_W'(arb_sum - CH_CNT) : arb_sum[CH_W-1:0];
  assign nxt_sum = {1'b0, arb_idx} + CW1'(1);
  assign rr_next = (nxt_sum >= CH_CNT) ? '0 : nxt_sum[CH_W-1:0];

  // Returns only count while filling; anything else on mem_valid is stale or stray.
  logic fill_hit, last_hit;
  assign fill_hit  = (state == FILL) & mem_valid;
  assign last_hit  = fill_hit & (rcv_cnt == LAST_OFF);
  assign fill_word = fill_hit ? rcv_cnt : '0;
  assign fill_data = fill_hit ? mem_rdata : '0;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    cache_fill_lane u_lane (
      .sel         (chan == CH_W'(g)),
      .fill_hit    (fill_hit),
      .last_hit    (last_hit),
      .fill_we     (fill_we[g]),
      .fill_tag_we (fill_tag_we[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      chan      <= '0;
      rr_ptr    <= '0;
      blk_tag   <= '0;
      iss_cnt   <= '0;
      rcv_cnt   <= '0;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            chan    <= arb_idx;
            grant   <= CHANNELS'(1) << arb_idx;
            busy    <= 1'b1;
            mem_en  <= 1'b1;
            blk_tag <= req_addr_a[arb_idx][ADDR_W-1:OFF_W+1];
            rcv_cnt <= '0;
            if (RR_MODE != 0) rr_ptr <= rr_next;
            if (req_write[arb_idx]) begin
              state     <= WRITE;
              mem_wr    <= 1'b1;
              mem_addr  <= req_addr_a[arb_idx];
              mem_wdata <= req_wdata_a[arb_idx];
            end else begin
              // Word 0 goes out on the grant edge; the counter names the next word.
              state     <= FILL;
              mem_wr    <= 1'b0;
              mem_addr  <= {req_addr_a[arb_idx][ADDR_W-1:OFF_W+1], {OW1{1'b0}}};
              mem_wdata <= '0;
              iss_cnt   <= OW1'(1);
            end
          end
        end
        FILL: begin
          if (iss_cnt < WPB_CNT) begin
            mem_addr <= {blk_tag, iss_cnt[OFF_W-1:0], 1'b0};
            iss_cnt  <= iss_cnt + OW1'(1);
          end else begin
            mem_en <= 1'b0;
          end
          if (mem_valid) begin
            if (rcv_cnt == LAST_OFF) begin
              state  <= DONE;
              done   <= grant;
              grant  <= '0;
              mem_en <= 1'b0;
            end else begin
              rcv_cnt <= rcv_cnt + OFF_W'(1);
            end
          end
        end
        WRITE: begin
          state  <= DONE;
          done   <= grant;
          grant  <= '0;
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: fixed-priority instance driven from a vector table with a
// scoreboard on memory/fill/done traffic, plus a round-robin instance for grant rotation.

module tb_cache_fill_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // fixed-priority DUT
  logic [1:0]  req_valid = '0, req_write = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  grant, done, fill_we, fill_tag_we;
  logic [2:0]  fill_word;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
  logic        busy, mem_en, mem_wr, mem_valid;
  logic        stray = 1'b0;

  // round-robin DUT
  logic [1:0]  r_req_valid = '0, r_req_write = '0;
  logic [31:0] r_req_addr = '0, r_req_wdata = '0;
  logic [1:0]  r_grant, r_done, r_fill_we, r_fill_tag_we;
  logic [2:0]  r_fill_word;
  logic [15:0] r_fill_data, r_mem_addr, r_mem_wdata, r_mem_rdata;
  logic        r_busy, r_mem_en, r_mem_wr, r_mem_valid;

  cache_fill_arbiter #(.RR_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done),
    .fill_we(fill_we), .fill_tag_we(fill_tag_we), .fill_word(fill_word),
    .fill_data(fill_data), .busy(busy), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid));

  cache_fill_arbiter #(.RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(r_req_valid), .req_write(r_req_write),
    .req_addr(r_req_addr), .req_wdata(r_req_wdata), .grant(r_grant), .done(r_done),
    .fill_we(r_fill_we), .fill_tag_we(r_fill_tag_we), .fill_word(r_fill_word),
    .fill_data(r_fill_data), .busy(r_busy), .mem_en(r_mem_en), .mem_wr(r_mem_wr),
    .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_rdata(r_mem_rdata),
    .mem_valid(r_mem_valid));

  // Memory: fixed 4-cycle read pipeline, word k of any block returns 0xA000+k. Not reset.
  logic [3:0]       vpipe = '0, r_vpipe = '0;
  logic [3:0][15:0] apipe = '0, r_apipe = '0;
  always @(posedge clk) begin
    vpipe   <= {vpipe[2:0], mem_en & ~mem_wr};
    apipe   <= {apipe[2:0], mem_addr};
    r_vpipe <= {r_vpipe[2:0], r_mem_en & ~r_mem_wr};
    r_apipe <= {r_apipe[2:0], r_mem_addr};
  end
  assign mem_valid   = vpipe[3] | stray;
  assign mem_rdata   = 16'hA000 + {13'd0, apipe[3][3:1]};
  assign r_mem_valid = r_vpipe[3];
  assign r_mem_rdata = 16'hA000 + {13'd0, r_apipe[3][3:1]};

  typedef struct packed { logic wr; logic [15:0] addr; logic [15:0] wdata; } mem_t;
  typedef struct packed { logic [1:0] we; logic [2:0] word; logic [15:0] data; logic tag; } fill_t;
  typedef struct {
    int ch; bit wr; logic [15:0] addr; logic [15:0] wdata; logic [15:0] base; int lat;
  } vec_t;

  mem_t       exp_mem[$];
  fill_t      exp_fill[$];
  logic [1:0] exp_done[$];
  bit         sb_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    mem_t m; fill_t f; logic [1:0] d;
    if (!sb_en) return;
    if (mem_en) begin
      if (exp_mem.size() == 0) chk("mem_unexp", {63'd0, mem_en}, 64'd0);
      else begin
        m = exp_mem.pop_front();
        chk("mem_wr", {63'd0, mem_wr}, {63'd0, m.wr});
        chk("mem_addr", {48'd0, mem_addr}, {48'd0, m.addr});
        if (m.wr) chk("mem_wdata", {48'd0, mem_wdata}, {48'd0, m.wdata});
      end
    end
    if (fill_we != 0) begin
      if (exp_fill.size() == 0) chk("fill_unexp", {62'd0, fill_we}, 64'd0);
      else begin
        f = exp_fill.pop_front();
        chk("fill_we", {62'd0, fill_we}, {62'd0, f.we});
        chk("fill_word", {61'd0, fill_word}, {61'd0, f.word});
        chk("fill_data", {48'd0, fill_data}, {48'd0, f.data});
        chk("fill_tag_we", {62'd0, fill_tag_we}, f.tag ? {62'd0, f.we} : 64'd0);
      end
    end
    if (done != 0) begin
      if (exp_done.size() == 0) chk("done_unexp", {62'd0, done}, 64'd0);
      else begin
        d = exp_done.pop_front();
        chk("done", {62'd0, done}, {62'd0, d});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic push_exp(input int ch, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] base);
    logic [1:0] oh;
    oh = 2'(1 << ch);
    if (wr) exp_mem.push_back('{1'b1, addr, wdata});
    else
      for (int k = 0; k < 8; k++) begin
        exp_mem.push_back('{1'b0, base + 16'(2 * k), 16'h0});
        exp_fill.push_back('{oh, 3'(k), 16'hA000 + 16'(k), (k == 7)});
      end
    exp_done.push_back(oh);
  endtask

  task automatic drive(input int ch, input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
    req_valid[ch] = 1'b1;
    req_write[ch] = wr;
    req_addr[ch*16 +: 16]  = addr;
    req_wdata[ch*16 +: 16] = wdata;
  endtask

  task automatic wait_grant(output int g);
    int n = 0;
    while (grant == 0 && n < 20) begin tick(); n++; end
    g = cyc;
  endtask

  // Waits for done, noting the first fill_we and the tag-write cycles on the way.
  task automatic wait_done(output int d, output int f1, output int tg);
    int n = 0;
    f1 = -1; tg = -1;
    while (done == 0 && n < 40) begin
      tick(); n++;
      if (fill_we != 0 && f1 < 0) f1 = cyc;
      if (fill_tag_we != 0) tg = cyc;
    end
    d = cyc;
  endtask

  task automatic run_txn(input vec_t v);
    int g, d, f1, tg;
    push_exp(v.ch, v.wr, v.addr, v.wdata, v.base);
    drive(v.ch, v.wr, v.addr, v.wdata);
    wait_grant(g);
    chk("grant", {62'd0, grant}, {62'd0, 2'(1 << v.ch)});
    chk("issue_at_grant", {63'd0, mem_en}, 64'd1);
    wait_done(d, f1, tg);
    chk("done_latency", 64'(d - g), 64'(v.lat));
    if (!v.wr) begin
      chk("first_fill_latency", 64'(f1 - g), 64'd4);
      chk("tag_before_done", 64'(d - tg), 64'd1);
    end
    chk("grant_in_done", {62'd0, grant}, 64'd0);
    chk("busy_in_done", {63'd0, busy}, 64'd1);
    req_valid[v.ch] = 1'b0;
    tick();
    chk("busy_after", {63'd0, busy}, 64'd0);
    chk("sb_drain", 64'(exp_mem.size() + exp_fill.size() + exp_done.size()), 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return {2'b0, grant, done, fill_we, fill_tag_we, fill_word, fill_data, busy,
            mem_en, mem_wr, mem_addr, mem_wdata};
  endfunction

  initial begin
    vec_t vecs[5];
    int g0, d0, f1, tg, n;
    logic [1:0]  rr_g[4];
    int          rr_c[4];
    logic [15:0] rr_a[4];
    vecs[0] = '{0, 1'b0, 16'h1236, 16'h0000, 16'h1230, 12};
    vecs[1] = '{1, 1'b1, 16'h0041, 16'hBEEF, 16'h0000, 1};
    vecs[2] = '{1, 1'b0, 16'h00FF, 16'h0000, 16'h00F0, 12};
    vecs[3] = '{0, 1'b1, 16'hFFFE, 16'h1234, 16'h0000, 1};
    vecs[4] = '{0, 1'b0, 16'hFFFF, 16'h0000, 16'hFFF0, 12};

    tick(); tick();
    chk("reset_outs", all_outs(), 64'd0);
    chk("reset_rr_outs", {r_grant, r_done, r_busy, r_mem_en}, 64'd0);
    rst_n = 1'b1;
    tick();
    sb_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i]);
      tick();
    end

    // mem_valid wiggling while idle must not produce any fill activity
    for (int i = 0; i < 6; i++) begin
      stray = i[0];
      tick();
      chk("idle_stray", {fill_we, fill_tag_we, done, busy}, 64'd0);
    end
    stray = 1'b0;
    tick();

    // same-cycle requests: ch0 first, ch1 two cycles after ch0's done
    push_exp(0, 1'b0, 16'h0300, 16'h0, 16'h0300);
    push_exp(1, 1'b0, 16'h0412, 16'h0, 16'h0410);
    drive(0, 1'b0, 16'h0300, 16'h0);
    drive(1, 1'b0, 16'h0412, 16'h0);
    wait_grant(g0);
    chk("prio_first", {62'd0, grant}, 64'd1);
    wait_done(d0, f1, tg);
    req_valid[0] = 1'b0;
    tick();
    chk("prio_gap", {62'd0, grant}, 64'd0);
    tick();
    chk("prio_second", {62'd0, grant}, 64'd2);
    wait_done(d0, f1, tg);
    req_valid[1] = 1'b0;
    tick(); tick();
    chk("prio_drain", 64'(exp_mem.size() + exp_fill.size() + exp_done.size()), 64'd0);

    // reset in the middle of a fill
    push_exp(0, 1'b0, 16'h2000, 16'h0, 16'h2000);
    drive(0, 1'b0, 16'h2000, 16'h0);
    wait_grant(g0);
    for (int i = 0; i < 5; i++) tick();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    sb_en = 1'b0;
    exp_mem.delete(); exp_fill.delete(); exp_done.delete();
    #1;
    chk("midfill_reset_outs", all_outs(), 64'd0);
    tick();
    chk("in_reset_fill", {62'd0, fill_we}, 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      stray = i[0];
      tick();
      chk("post_reset_stray", {fill_we, fill_tag_we, done, busy}, 64'd0);
    end
    stray = 1'b0;
    tick(); tick();
    sb_en = 1'b1;
    run_txn('{0, 1'b0, 16'h2468, 16'h0000, 16'h2460, 12});

    // round-robin: both channels hold write requests
    for (int i = 0; i < 4; i++) begin rr_g[i] = '0; rr_c[i] = 0; rr_a[i] = '0; end
    r_req_write = 2'b11;
    r_req_addr  = {16'h0202, 16'h0100};
    r_req_wdata = {16'h2222, 16'h1111};
    r_req_valid = 2'b11;
    n = 0;
    for (int t = 0; t < 40 && n < 4; t++) begin
      tick();
      if (r_grant != 0) begin
        rr_g[n] = r_grant; rr_c[n] = cyc; rr_a[n] = r_mem_addr;
        n++;
      end
    end
    r_req_valid = 2'b00;
    chk("rr_g0", {62'd0, rr_g[0]}, 64'd1);
    chk("rr_g1", {62'd0, rr_g[1]}, 64'd2);
    chk("rr_g2", {62'd0, rr_g[2]}, 64'd1);
    chk("rr_g3", {62'd0, rr_g[3]}, 64'd2);
    chk("rr_addr0", {48'd0, rr_a[0]}, 64'h0100);
    chk("rr_addr1", {48'd0, rr_a[1]}, 64'h0202);
    for (int i = 1; i < 4; i++) chk("rr_spacing", 64'(rr_c[i] - rr_c[i-1]), 64'd3);
    tick(); tick(); tick();
    chk("rr_idle", {r_busy, r_grant}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
